// File: rtl/camera_emu_pkg.sv
// Shared types and constants for the parallel-bus camera emulator.
// Provides the frame FSM state enum, RGB565 colour constants and counter widths.
package camera_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } emu_state_t;

  localparam logic [15:0] RED_565   = 16'hF800;
  localparam logic [15:0] BLACK_565 = 16'h0000;

  // Counter widths sized for the default 784-pclk line and 240-line phases.
  localparam int unsigned COL_W   = 11;
  localparam int unsigned LINE_W  = 9;
  localparam int unsigned PHASE_W = 8;

endpackage

// File: rtl/camera_emu_timing.sv
// Pixel-clock generator and frame sequencer for the camera emulator.
// Ports:
//   clk_in, rst_in (sync, active-low), enable_in : clock, reset, run request
//   state, col, line : bus position that the next tick will present
//   new_frame, end_frame : position entered a new frame / just left VFRONT
//   pclk   : registered pixel clock
//   tick_c : phase is about to wrap to 0 (pclk falling edge, bus update)
module camera_emu_timing
  import camera_emu_pkg::*;
#(
  parameter int unsigned PCLK_HALF   = 4,
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  output emu_state_t        state,
  output logic [COL_W-1:0]  col,
  output logic [LINE_W-1:0] line,
  output logic              new_frame,
  output logic              end_frame,
  output logic              pclk,
  output logic              tick_c
);

  localparam int unsigned PHASE_LAST = 2 * PCLK_HALF - 1;
  localparam int unsigned LINE_LAST  = 2 * H_ACTIVE + H_BLANK - 1;

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt_c;
  logic [LINE_W-1:0]  lines_last_c;
  logic               running_c;
  logic               adv_c;

  // Phase runs while framing, while a start is requested, or to finish a pclk.
  // The position advances one clk before the tick so the top can register
  // bus outputs from it exactly on the tick.
  always_comb begin
    running_c   = (state != IDLE) || enable_in || (phase != '0);
    phase_nxt_c = phase;
    if (running_c) begin
      phase_nxt_c = (phase == PHASE_W'(PHASE_LAST)) ? '0 : phase + PHASE_W'(1);
    end
    tick_c = running_c && (phase == PHASE_W'(PHASE_LAST));
    adv_c  = running_c && (phase == PHASE_W'(PHASE_LAST - 1));
    case (state)
      VSYNC:   lines_last_c = LINE_W'(VSYNC_LINES - 1);
      VBACK:   lines_last_c = LINE_W'(V_BACK - 1);
      ACTIVE:  lines_last_c = LINE_W'(V_ACTIVE - 1);
      default: lines_last_c = LINE_W'(V_FRONT - 1);
    endcase
  end

  // Phase, pclk and frame position sequencer.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phase     <= '0;
      pclk      <= 1'b0;
      state     <= IDLE;
      col       <= '0;
      line      <= '0;
      new_frame <= 1'b0;
      end_frame <= 1'b0;
    end else begin
      phase <= phase_nxt_c;
      pclk  <= (phase_nxt_c >= PHASE_W'(PCLK_HALF));
      if (adv_c) begin
        new_frame <= 1'b0;
        end_frame <= 1'b0;
        if (state == IDLE) begin
          state     <= VSYNC;
          col       <= '0;
          line      <= '0;
          new_frame <= 1'b1;
        end else if (col != COL_W'(LINE_LAST)) begin
          col <= col + COL_W'(1);
        end else begin
          col <= '0;
          if (line != lines_last_c) begin
            line <= line + LINE_W'(1);
          end else begin
            line <= '0;
            case (state)
              VSYNC:  state <= VBACK;
              VBACK:  state <= ACTIVE;
              ACTIVE: state <= VFRONT;
              default: begin
                end_frame <= 1'b1;
                if (enable_in) begin
                  state     <= VSYNC;
                  new_frame <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/camera_emulator.sv
// 8-bit parallel camera bus transmitter: RGB565 frames of a flat background
// with one square dot of programmable colour and position.
// Ports:
//   clk_in, rst_in (sync, active-low), enable_in (sampled at frame boundaries)
//   bg_color_in, dot_color_in, dot_x_in, dot_y_in, dot_en_in : frame settings
//   cam_pclk_out, cam_vsync_out, cam_href_out, cam_data_out  : camera bus
//   frame_start_out : one-cycle pulse as VSYNC rises
//   frame_count_out : completed frames, wraps
module camera_emulator
  import camera_emu_pkg::*;
#(
  parameter int unsigned PCLK_HALF   = 4,
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned DOT_SIZE    = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [15:0] bg_color_in,
  input  logic [15:0] dot_color_in,
  input  logic [8:0]  dot_x_in,
  input  logic [7:0]  dot_y_in,
  input  logic        dot_en_in,
  output logic        cam_pclk_out,
  output logic        cam_vsync_out,
  output logic        cam_href_out,
  output logic [7:0]  cam_data_out,
  output logic        frame_start_out,
  output logic [15:0] frame_count_out
);

  emu_state_t        state;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic              new_frame;
  logic              end_frame;
  logic              pclk;
  logic              tick_c;

  camera_emu_timing #(
    .PCLK_HALF  (PCLK_HALF),
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .enable_in(enable_in),
    .state    (state),
    .col      (col),
    .line     (line),
    .new_frame(new_frame),
    .end_frame(end_frame),
    .pclk     (pclk),
    .tick_c   (tick_c)
  );

  assign cam_pclk_out = pclk;

  // Frame settings frozen at each frame start.
  logic [15:0] sh_bg;
  logic [15:0] sh_dot;
  logic [8:0]  sh_x;
  logic [7:0]  sh_y;
  logic        sh_en;

  logic [9:0]  pix_k_c;
  logic        in_x_c;
  logic        in_y_c;
  logic [15:0] pixel_c;
  logic        href_c;
  logic [7:0]  byte_c;

  // Dot compare is one bit wider than the coordinates so a dot past the edge
  // is clipped instead of wrapping to column/line 0.
  always_comb begin
    pix_k_c = 10'(col >> 1);
    in_x_c  = (pix_k_c >= {1'b0, sh_x}) && (pix_k_c < ({1'b0, sh_x} + 10'(DOT_SIZE)));
    in_y_c  = (line >= {1'b0, sh_y}) && (line < ({1'b0, sh_y} + 9'(DOT_SIZE)));
    pixel_c = (sh_en && in_x_c && in_y_c) ? sh_dot : sh_bg;
    href_c  = (state == ACTIVE) && (col < COL_W'(2 * H_ACTIVE));
    byte_c  = col[0] ? pixel_c[7:0] : pixel_c[15:8];
  end

  // Bus outputs, settings latch and frame counter, all updated on ticks.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cam_vsync_out   <= 1'b0;
      cam_href_out    <= 1'b0;
      cam_data_out    <= 8'h00;
      frame_start_out <= 1'b0;
      frame_count_out <= 16'h0000;
      sh_bg           <= BLACK_565;
      sh_dot          <= RED_565;
      sh_x            <= 9'd0;
      sh_y            <= 8'd0;
      sh_en           <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      if (tick_c) begin
        cam_vsync_out <= (state == VSYNC);
        cam_href_out  <= href_c;
        cam_data_out  <= href_c ? byte_c : 8'h00;
        if (new_frame) begin
          sh_bg           <= bg_color_in;
          sh_dot          <= dot_color_in;
          sh_x            <= dot_x_in;
          sh_y            <= dot_y_in;
          sh_en           <= dot_en_in;
          frame_start_out <= 1'b1;
        end
        if (end_frame) begin
          frame_count_out <= frame_count_out + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_emulator.sv
// Scoreboard bench for camera_emulator with a reduced frame geometry.
module tb_camera_emulator;

  localparam int PH = 2;
  localparam int HA = 12;
  localparam int VA = 8;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VBK = 2;
  localparam int VF = 1;
  localparam int DS = 3;
  localparam int FRAME_CYC = (2 * HA + HB) * (VS + VBK + VA + VF) * 2 * PH;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [15:0] bg_color_in;
  logic [15:0] dot_color_in;
  logic [8:0]  dot_x_in;
  logic [7:0]  dot_y_in;
  logic        dot_en_in;
  logic        cam_pclk_out;
  logic        cam_vsync_out;
  logic        cam_href_out;
  logic [7:0]  cam_data_out;
  logic        frame_start_out;
  logic [15:0] frame_count_out;

  camera_emulator #(
    .PCLK_HALF(PH), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VBK), .V_FRONT(VF), .DOT_SIZE(DS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .bg_color_in(bg_color_in), .dot_color_in(dot_color_in),
    .dot_x_in(dot_x_in), .dot_y_in(dot_y_in), .dot_en_in(dot_en_in),
    .cam_pclk_out(cam_pclk_out), .cam_vsync_out(cam_vsync_out),
    .cam_href_out(cam_href_out), .cam_data_out(cam_data_out),
    .frame_start_out(frame_start_out), .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         exp_fc_q[$];
  int         exp_gap_q[$];
  int         fc_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out or unexpected at %0t", name, $time);
  endtask

  // Expected byte stream of one frame's active lines.
  task automatic push_frame(input logic [15:0] bg, input logic [15:0] dot,
                            input int x, input int y, input logic en);
    logic [15:0] pix;
    for (int ln = 0; ln < VA; ln++) begin
      for (int b = 0; b < 2 * HA; b++) begin
        int k;
        k = b / 2;
        pix = (en && k >= x && k < x + DS && ln >= y && ln < y + DS) ? dot : bg;
        exp_q.push_back((b % 2 == 1) ? pix[7:0] : pix[15:8]);
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (frame_start_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_count(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (int'(frame_count_out) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drive settings for the next frame, await its start, then queue its bytes.
  task automatic start_frame(input logic [15:0] bg, input logic [15:0] dot,
                             input logic [8:0] x, input logic [7:0] y,
                             input logic en, input int gap);
    bit ok;
    bg_color_in  = bg;
    dot_color_in = dot;
    dot_x_in     = x;
    dot_y_in     = y;
    dot_en_in    = en;
    enable_in    = 1'b1;
    exp_fc_q.push_back(fc_exp);
    exp_gap_q.push_back(gap);
    wait_fs(ok);
    if (!ok) fail_now("frame_start_wait");
    else begin
      push_frame(bg, dot, int'(x), int'(y), en);
      fc_exp++;
    end
    repeat (600) @(negedge clk_in);
  endtask

  // Monitor: samples bytes on pclk rises and frame events, checks against queues.
  int  cyc = 0;
  int  last_rise = 0;
  int  last_fs = 0;
  int  line_bytes = 0;
  int  href_lines = 0;
  bit  fs_seen = 1'b0;
  bit  prev_pclk = 1'b0;
  bit  prev_href = 1'b0;

  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_in) begin
        prev_pclk  = 1'b0;
        prev_href  = 1'b0;
        line_bytes = 0;
        href_lines = 0;
        fs_seen    = 1'b0;
      end else begin
        if (cam_pclk_out && !prev_pclk) begin
          if (cam_href_out) begin
            if (line_bytes > 0) check("pclk_period", cyc - last_rise, 2 * PH);
            if (exp_q.size() == 0) fail_now("byte_unexpected");
            else check("pixel_byte", int'(cam_data_out), int'(exp_q.pop_front()));
            line_bytes++;
          end else begin
            check("blank_data", int'(cam_data_out), 0);
          end
          last_rise = cyc;
        end
        if (prev_href && !cam_href_out) begin
          check("line_bytes", line_bytes, 2 * HA);
          line_bytes = 0;
          href_lines++;
        end
        if (frame_start_out) begin
          check("vsync_at_start", int'(cam_vsync_out), 1);
          if (fs_seen) check("href_lines", href_lines, VA);
          href_lines = 0;
          if (exp_fc_q.size() == 0) fail_now("frame_unexpected");
          else begin
            int g;
            check("frame_count_at_start", int'(frame_count_out), exp_fc_q.pop_front());
            g = exp_gap_q.pop_front();
            if (g != 0) check("frame_period", cyc - last_fs, g);
          end
          fs_seen = 1'b1;
          last_fs = cyc;
        end
        prev_pclk = cam_pclk_out;
        prev_href = cam_href_out;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int busy;
    rst_in       = 1'b0;
    enable_in    = 1'b0;
    bg_color_in  = 16'h0;
    dot_color_in = 16'h0;
    dot_x_in     = 9'd0;
    dot_y_in     = 8'd0;
    dot_en_in    = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_bus", int'({cam_pclk_out, cam_vsync_out, cam_href_out, cam_data_out, frame_start_out}), 0);
    check("reset_count", int'(frame_count_out), 0);
    rst_in = 1'b1;

    // Dot at (4,2): line 2 bytes 8..13 = F8,00 pairs, byte 14 background.
    start_frame(16'h0000, 16'hF800, 9'd4, 8'd2, 1'b1, 0);
    // Corner dot at (10,6) clipped to columns 10-11 of lines 6-7.
    start_frame(16'h0000, 16'hF800, 9'd10, 8'd6, 1'b1, FRAME_CYC);
    // Dot far off-screen: must not wrap onto column 0 or line 0.
    start_frame(16'h1234, 16'hF800, 9'd510, 8'd254, 1'b1, FRAME_CYC);
    // Dot at origin; enable dropped mid-frame so this is the last frame.
    start_frame(16'hA5C3, 16'h07E0, 9'd0, 8'd0, 1'b1, FRAME_CYC);
    enable_in = 1'b0;
    wait_count(4, ok);
    if (!ok) fail_now("frame_count_wait");
    check("frame_count_done", int'(frame_count_out), 4);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (cam_pclk_out || cam_vsync_out || cam_href_out || frame_start_out || cam_data_out != 8'h00)
        busy++;
    end
    check("idle_quiet", busy, 0);
    check("idle_count_held", int'(frame_count_out), 4);

    // Restart from IDLE, then reset in the middle of an active line.
    start_frame(16'h00FF, 16'hFFFF, 9'd5, 8'd3, 1'b1, 0);
    check("href_mid_active", int'(cam_href_out), 1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midline_reset_bus", int'({cam_pclk_out, cam_vsync_out, cam_href_out, cam_data_out, frame_start_out}), 0);
    check("midline_reset_count", int'(frame_count_out), 0);
    repeat (4) @(negedge clk_in);
    exp_q.delete();
    exp_fc_q.delete();
    exp_gap_q.delete();
    fc_exp = 0;
    exp_fc_q.push_back(0);
    exp_gap_q.push_back(0);
    rst_in = 1'b1;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      n++;
      if (frame_start_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("restart_wait");
    check("vsync_latency", n, 2 * PH);
    check("vsync_after_restart", int'(cam_vsync_out), 1);
    push_frame(16'h00FF, 16'hFFFF, 5, 3, 1'b1);
    enable_in = 1'b0;
    wait_count(1, ok);
    if (!ok) fail_now("final_frame_wait");
    check("final_count", int'(frame_count_out), 1);
    repeat (10) @(negedge clk_in);
    check("bytes_left", exp_q.size(), 0);
    check("frames_left", exp_fc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
